fpadd_arbiter: RTL and testbench

- Shares one floating-point adder (stb/ack handshake, 32-bit IEEE-754 single) among N_REQ requesters, e.g. matrix-multiplier accumulation lanes.
- Round-robin grant, one operation in flight.
- Sequences operand delivery, result capture and result return to the granted requester.

---
 rtl/fpadd_pkg.sv | 18 +
 rtl/rr_arbiter.sv | 34 +++
 rtl/fpadd_arbiter.sv | 254 +++++++++++++++++++++++++
 tb/tb_fpadd_arbiter.sv | 390 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fpadd_pkg.sv
// fpadd_pkg: shared types and constants for the shared FP adder arbiter.
// State encoding, IEEE-754 single constants and the default data width.
package fpadd_pkg;

  localparam int DEF_WIDTH = 32;

  localparam logic [31:0] FP_ONE  = 32'h3F800000;
  localparam logic [31:0] FP_TWO  = 32'h40000000;
  localparam logic [31:0] FP_MONE = 32'hBF800000;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SEND   = 2'd1,
    WAIT_Z = 2'd2,
    RESP   = 2'd3
  } arb_state_e;

endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational round-robin pick, first set bit after last.
// Ports: req (request vector), last (previous winner) -> any, gnt (one-hot), gnt_id.
module rr_arbiter
  import fpadd_pkg::*;
#(
  parameter int N    = 4,
  parameter int ID_W = $clog2(N)
) (
  input  logic [N-1:0]    req,
  input  logic [ID_W-1:0] last,
  output logic            any,
  output logic [N-1:0]    gnt,
  output logic [ID_W-1:0] gnt_id
);

  logic [ID_W-1:0] idx;

  // Walk last+1 .. last+N (mod N); the first hit wins.
  always_comb begin
    any    = 1'b0;
    gnt    = '0;
    gnt_id = '0;
    idx    = '0;
    for (int i = 1; i <= N; i++) begin
      idx = ID_W'((int'(last) + i) % N);
      if (!any && req[idx]) begin
        any      = 1'b1;
        gnt[idx] = 1'b1;
        gnt_id   = idx;
      end
    end
  end

endmodule

// File: rtl/fpadd_arbiter.sv
// fpadd_arbiter: shares one stb/ack FP adder among N_REQ requesters, round-robin.
// Ports: req_* in, rsp_* out, add_* to/from adder, busy, grant_id; op_count if FPADD_ARB_OPCNT_EN.
module fpadd_arbiter
  import fpadd_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int WIDTH = DEF_WIDTH,
  parameter int ID_W  = $clog2(N_REQ)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [N_REQ-1:0]       req_valid,
  input  logic [N_REQ*WIDTH-1:0] req_a,
  input  logic [N_REQ*WIDTH-1:0] req_b,
  output logic [N_REQ-1:0]       req_ready,
  output logic [N_REQ-1:0]       rsp_valid,
  output logic [WIDTH-1:0]       rsp_z,
  input  logic [N_REQ-1:0]       rsp_ready,
  output logic [WIDTH-1:0]       add_a,
  output logic                   add_a_stb,
  input  logic                   add_a_ack,
  output logic [WIDTH-1:0]       add_b,
  output logic                   add_b_stb,
  input  logic                   add_b_ack,
  input  logic [WIDTH-1:0]       add_z,
  input  logic                   add_z_stb,
  output logic                   add_z_ack,
`ifdef FPADD_ARB_OPCNT_EN
  output logic [15:0]            op_count,
`endif
  output logic                   busy,
  output logic [ID_W-1:0]        grant_id
);

  arb_state_e state_q;
  arb_state_e state_d;

  logic [ID_W-1:0]  last_q;
  logic [ID_W-1:0]  last_d;
  logic [ID_W-1:0]  gid_q;
  logic [ID_W-1:0]  gid_d;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] a_d;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] b_d;
  logic [WIDTH-1:0] z_q;
  logic [WIDTH-1:0] z_d;
  logic             a_stb_q;
  logic             a_stb_d;
  logic             b_stb_q;
  logic             b_stb_d;
  logic             a_done_q;
  logic             a_done_d;
  logic             b_done_q;
  logic             b_done_d;
  logic             z_ack_q;
  logic             z_ack_d;
  logic [N_REQ-1:0] rdy_q;
  logic [N_REQ-1:0] rdy_d;
  logic [N_REQ-1:0] vld_q;
  logic [N_REQ-1:0] vld_d;

  logic             arb_any;
  logic [N_REQ-1:0] arb_gnt;
  logic [ID_W-1:0]  arb_id;
  logic [WIDTH-1:0] a_sel;
  logic [WIDTH-1:0] b_sel;
  logic [N_REQ-1:0] gid_oh;
  logic             a_xfer;
  logic             b_xfer;
  logic             a_fin;
  logic             b_fin;
  logic             rsp_hs;

  rr_arbiter #(
    .N    (N_REQ),
    .ID_W (ID_W)
  ) u_rr (
    .req    (req_valid),
    .last   (last_q),
    .any    (arb_any),
    .gnt    (arb_gnt),
    .gnt_id (arb_id)
  );

  always_comb begin
    a_sel = '0;
    b_sel = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (arb_gnt[i]) begin
        a_sel = req_a[i*WIDTH +: WIDTH];
        b_sel = req_b[i*WIDTH +: WIDTH];
      end
    end
  end

  always_comb begin
    gid_oh = '0;
    for (int i = 0; i < N_REQ; i++) begin
      gid_oh[i] = (gid_q == ID_W'(i));
    end
  end

  assign a_xfer = a_stb_q & add_a_ack;
  assign b_xfer = b_stb_q & add_b_ack;
  assign a_fin  = a_done_q | a_xfer;
  assign b_fin  = b_done_q | b_xfer;
  // vld_q is only non-zero in RESP, and only on the granted bit.
  assign rsp_hs = |(vld_q & rsp_ready);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (arb_any) state_d = SEND;
      end
      SEND: begin
        if (a_fin && b_fin) state_d = WAIT_Z;
      end
      WAIT_Z: begin
        if (add_z_stb) state_d = RESP;
      end
      RESP: begin
        if (rsp_hs) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    last_d   = last_q;
    gid_d    = gid_q;
    a_d      = a_q;
    b_d      = b_q;
    z_d      = z_q;
    a_stb_d  = a_stb_q;
    b_stb_d  = b_stb_q;
    a_done_d = a_done_q;
    b_done_d = b_done_q;
    z_ack_d  = 1'b0;
    rdy_d    = '0;
    vld_d    = vld_q;
    unique case (state_q)
      IDLE: begin
        if (arb_any) begin
          gid_d    = arb_id;
          a_d      = a_sel;
          b_d      = b_sel;
          rdy_d    = arb_gnt;
          a_stb_d  = 1'b1;
          b_stb_d  = 1'b1;
          a_done_d = 1'b0;
          b_done_d = 1'b0;
        end
      end
      SEND: begin
        if (a_xfer) begin
          a_stb_d  = 1'b0;
          a_done_d = 1'b1;
        end
        if (b_xfer) begin
          b_stb_d  = 1'b0;
          b_done_d = 1'b1;
        end
      end
      WAIT_Z: begin
        if (add_z_stb) begin
          z_d     = add_z;
          z_ack_d = 1'b1;
          vld_d   = gid_oh;
        end
      end
      RESP: begin
        if (rsp_hs) begin
          vld_d  = '0;
          last_d = gid_q;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_q   <= ID_W'(N_REQ - 1);
      gid_q    <= '0;
      a_q      <= '0;
      b_q      <= '0;
      z_q      <= '0;
      a_stb_q  <= 1'b0;
      b_stb_q  <= 1'b0;
      a_done_q <= 1'b0;
      b_done_q <= 1'b0;
      z_ack_q  <= 1'b0;
      rdy_q    <= '0;
      vld_q    <= '0;
    end else begin
      last_q   <= last_d;
      gid_q    <= gid_d;
      a_q      <= a_d;
      b_q      <= b_d;
      z_q      <= z_d;
      a_stb_q  <= a_stb_d;
      b_stb_q  <= b_stb_d;
      a_done_q <= a_done_d;
      b_done_q <= b_done_d;
      z_ack_q  <= z_ack_d;
      rdy_q    <= rdy_d;
      vld_q    <= vld_d;
    end
  end

`ifdef FPADD_ARB_OPCNT_EN
  logic [15:0] cnt_q;
  logic [15:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (rsp_hs && (cnt_q != 16'hFFFF)) begin
      cnt_d = cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign op_count = cnt_q;
`endif

  assign req_ready = rdy_q;
  assign rsp_valid = vld_q;
  assign rsp_z     = z_q;
  assign add_a     = a_q;
  assign add_b     = b_q;
  assign add_a_stb = a_stb_q;
  assign add_b_stb = b_stb_q;
  assign add_z_ack = z_ack_q;
  assign busy      = (state_q != IDLE);
  assign grant_id  = gid_q;

endmodule

// File: tb/tb_fpadd_arbiter.sv
// tb_fpadd_arbiter: directed bench with an adder model and a response scoreboard.
// Builds with or without FPADD_ARB_OPCNT_EN.
module tb_fpadd_arbiter;
  import fpadd_pkg::*;

  localparam int N = 4;
  localparam int W = 32;

  logic           clk = 1'b0;
  logic           rst_n;
  logic [N-1:0]   req_valid;
  logic [N*W-1:0] req_a;
  logic [N*W-1:0] req_b;
  logic [N-1:0]   req_ready;
  logic [N-1:0]   rsp_valid;
  logic [W-1:0]   rsp_z;
  logic [N-1:0]   rsp_ready;
  logic [W-1:0]   add_a;
  logic           add_a_stb;
  logic           add_a_ack;
  logic [W-1:0]   add_b;
  logic           add_b_stb;
  logic           add_b_ack;
  logic [W-1:0]   add_z;
  logic           add_z_stb;
  logic           add_z_ack;
  logic           busy;
  logic [1:0]     grant_id;
`ifdef FPADD_ARB_OPCNT_EN
  logic [15:0]    op_count;
`endif

  int          total = 0;
  int          bad = 0;
  int          exp_id[$];
  logic [31:0] exp_z[$];
  int          ord_q[$];
  int          a_dly = 1;
  int          b_dly = 1;
  int          z_dly = 2;
  int          rdy_cnt[N];
  logic [31:0] m_a;
  logic [31:0] m_b;
  bit          ga;
  bit          gb;
  bit          ab;
  int          mk;

  fpadd_arbiter #(.N_REQ(N), .WIDTH(W), .ID_W(2)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_a     (req_a),
    .req_b     (req_b),
    .req_ready (req_ready),
    .rsp_valid (rsp_valid),
    .rsp_z     (rsp_z),
    .rsp_ready (rsp_ready),
    .add_a     (add_a),
    .add_a_stb (add_a_stb),
    .add_a_ack (add_a_ack),
    .add_b     (add_b),
    .add_b_stb (add_b_stb),
    .add_b_ack (add_b_ack),
    .add_z     (add_z),
    .add_z_stb (add_z_stb),
    .add_z_ack (add_z_ack),
`ifdef FPADD_ARB_OPCNT_EN
    .op_count  (op_count),
`endif
    .busy      (busy),
    .grant_id  (grant_id)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, req);
    end
  endtask

  // Stand-in adder: sums for the operand pairs used below.
  function automatic logic [31:0] fp_sum(input logic [31:0] x,
                                         input logic [31:0] y);
    logic [31:0] r;
    case ({x, y})
      {FP_ONE, FP_ONE}:                    r = FP_TWO;
      {FP_ONE, FP_TWO}, {FP_TWO, FP_ONE}:  r = 32'h40400000;
      {FP_TWO, FP_TWO}:                    r = 32'h40800000;
      {FP_TWO, FP_MONE}, {FP_MONE, FP_TWO}: r = FP_ONE;
      {FP_ONE, FP_MONE}, {FP_MONE, FP_ONE}: r = 32'h00000000;
      default:                             r = 32'hDEADBEEF;
    endcase
    return r;
  endfunction

  task automatic setop(input int i, input logic [31:0] a,
                       input logic [31:0] b);
    req_a[i*W +: W] = a;
    req_b[i*W +: W] = b;
  endtask

  task automatic push(input int id, input logic [31:0] z);
    exp_id.push_back(id);
    exp_z.push_back(z);
  endtask

  task automatic take_grants(input int n);
    int got;
    int t;
    int id;
    int want;
    bit keep;
    got = 0;
    t = 0;
    while (got < n && t < 500) begin
      @(negedge clk);
      t++;
      if (req_ready != '0) begin
        id = 0;
        for (int i = 0; i < N; i++) if (req_ready[i]) id = i;
        want = (ord_q.size() != 0) ? ord_q.pop_front() : -1;
        chk("grant order", id, want);
        chk("req_ready onehot", 32'($onehot(req_ready)), 1);
        chk("grant_id", 32'(grant_id), want);
        got++;
        keep = 0;
        foreach (ord_q[j]) if (ord_q[j] == id) keep = 1;
        if (!keep) req_valid[id] = 1'b0;
      end
    end
    if (got < n) begin
      total++;
      bad++;
      $display("FAIL grant timeout: got %0d want %0d", got, n);
    end
  endtask

  task automatic drain(input string nm);
    int t;
    t = 0;
    while ((busy || exp_z.size() != 0) && t < 300) begin
      @(negedge clk);
      t++;
    end
    chk({nm, " idle"}, 32'(busy), 0);
    chk({nm, " drained"}, exp_z.size(), 0);
    chk({nm, " rsp_valid low"}, 32'(rsp_valid), 0);
  endtask

  initial forever begin
    @(negedge clk);
    for (int i = 0; i < N; i++) if (req_ready[i]) rdy_cnt[i]++;
  end

  // Scoreboard monitor: pops one expectation per response handshake.
  initial forever begin
    int id;
    logic [31:0] z;
    @(negedge clk);
    if (rst_n && ((rsp_valid & rsp_ready) != '0)) begin
      if (exp_z.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected rsp: rsp_valid=%b rsp_z=%h",
                 rsp_valid, rsp_z);
      end else begin
        id = exp_id.pop_front();
        z = exp_z.pop_front();
        chk("rsp_valid", 32'(rsp_valid), 32'(1) << id);
        chk("rsp_z", rsp_z, z);
        chk("rsp grant_id", 32'(grant_id), id);
      end
    end
  end

  // Adder model: ack delays per operand, result after z_dly cycles.
  initial begin
    add_a_ack = 1'b0;
    add_b_ack = 1'b0;
    add_z_stb = 1'b0;
    add_z = '0;
    forever begin
      @(negedge clk);
      if (rst_n && add_a_stb && add_b_stb) begin
        m_a = add_a;
        m_b = add_b;
        ga = 0;
        gb = 0;
        ab = 0;
        mk = 1;
        while (!ab && !(ga && gb) && mk < 40) begin
          add_a_ack = !ga && (mk >= a_dly);
          add_b_ack = !gb && (mk >= b_dly);
          @(negedge clk);
          if (add_a_ack) ga = 1;
          if (add_b_ack) gb = 1;
          add_a_ack = 1'b0;
          add_b_ack = 1'b0;
          if (!rst_n) ab = 1;
          mk++;
        end
        mk = 0;
        while (!ab && mk < z_dly) begin
          @(negedge clk);
          mk++;
          if (!rst_n) ab = 1;
        end
        if (!ab) begin
          add_z = fp_sum(m_a, m_b);
          add_z_stb = 1'b1;
          mk = 0;
          while (!ab && !add_z_ack && mk < 50) begin
            @(negedge clk);
            mk++;
            if (!rst_n) ab = 1;
          end
          if (!ab) @(negedge clk);
          add_z_stb = 1'b0;
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: sim time %0t limit 100000", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int t;
    int c0;
    int gap;
    rst_n = 1'b0;
    req_valid = '0;
    req_a = '0;
    req_b = '0;
    rsp_ready = '1;
    repeat (2) @(negedge clk);
    chk("rst req_ready", 32'(req_ready), 0);
    chk("rst rsp_valid", 32'(rsp_valid), 0);
    chk("rst add_a_stb", 32'(add_a_stb), 0);
    chk("rst add_b_stb", 32'(add_b_stb), 0);
    chk("rst add_z_ack", 32'(add_z_ack), 0);
    chk("rst busy", 32'(busy), 0);
    chk("rst grant_id", 32'(grant_id), 0);
    chk("rst rsp_z", rsp_z, 0);
`ifdef FPADD_ARB_OPCNT_EN
    chk("rst op_count", 32'(op_count), 0);
`endif
    rst_n = 1'b1;

    // all four from reset: 0,1,2,3 then 0 again
    setop(0, FP_ONE, FP_ONE);
    setop(1, FP_ONE, FP_TWO);
    setop(2, FP_TWO, FP_TWO);
    setop(3, FP_TWO, FP_MONE);
    push(0, FP_TWO);
    push(1, 32'h40400000);
    push(2, 32'h40800000);
    push(3, FP_ONE);
    push(0, FP_TWO);
    ord_q = '{0, 1, 2, 3, 0};
    req_valid = '1;
    take_grants(5);
    drain("rr4");

    // single request on requester 0
    c0 = rdy_cnt[0];
    setop(0, FP_ONE, FP_ONE);
    push(0, FP_TWO);
    ord_q = '{0};
    req_valid[0] = 1'b1;
    take_grants(1);
    drain("single");
    chk("single ready pulses", rdy_cnt[0] - c0, 1);
    chk("single adder a", m_a, FP_ONE);
    chk("single adder b", m_b, FP_ONE);

    // requester 2 stalls its response for 20 cycles
    setop(2, FP_TWO, FP_TWO);
    push(2, 32'h40800000);
    ord_q = '{2};
    rsp_ready[2] = 1'b0;
    req_valid[2] = 1'b1;
    take_grants(1);
    t = 0;
    while (!rsp_valid[2] && t < 100) begin
      @(negedge clk);
      t++;
    end
    chk("stall rsp_valid", 32'(rsp_valid), 32'h4);
    setop(0, FP_ONE, FP_TWO);
    push(0, 32'h40400000);
    req_valid[0] = 1'b1;
    repeat (20) begin
      @(negedge clk);
      chk("stall hold valid", 32'(rsp_valid), 32'h4);
      chk("stall hold z", rsp_z, 32'h40800000);
      chk("stall no grant", 32'(req_ready), 0);
      chk("stall a_stb", 32'(add_a_stb), 0);
    end
    @(posedge clk);
    #1 rsp_ready[2] = 1'b1;
    ord_q = '{0};
    take_grants(1);
    drain("stall");

    // b acked 3 cycles ahead of a; 1.0 + -1.0
    a_dly = 4;
    b_dly = 1;
    z_dly = 0;
    setop(1, FP_ONE, FP_MONE);
    push(1, 32'h00000000);
    ord_q = '{1};
    req_valid[1] = 1'b1;
    take_grants(1);
    t = 0;
    while (add_b_stb && t < 20) begin
      @(negedge clk);
      t++;
    end
    chk("skew a_stb pending", 32'(add_a_stb), 1);
    chk("skew no z_ack", 32'(add_z_ack), 0);
    gap = 0;
    while (add_a_stb && gap < 20) begin
      @(negedge clk);
      gap++;
    end
    chk("skew gap", gap, 3);
    chk("skew b_stb low", 32'(add_b_stb), 0);
    drain("skew");
    a_dly = 1;
    b_dly = 1;
    z_dly = 2;
`ifdef FPADD_ARB_OPCNT_EN
    chk("op_count 9", 32'(op_count), 9);
`endif

    // reset while waiting on the adder result
    z_dly = 30;
    setop(3, FP_TWO, FP_TWO);
    push(3, 32'h40800000);
    ord_q = '{3};
    req_valid[3] = 1'b1;
    take_grants(1);
    repeat (6) @(negedge clk);
    chk("wz busy", 32'(busy), 1);
    chk("wz a_stb", 32'(add_a_stb), 0);
    #2 rst_n = 1'b0;
    #1;
    chk("arst req_ready", 32'(req_ready), 0);
    chk("arst rsp_valid", 32'(rsp_valid), 0);
    chk("arst add_a_stb", 32'(add_a_stb), 0);
    chk("arst add_b_stb", 32'(add_b_stb), 0);
    chk("arst add_z_ack", 32'(add_z_ack), 0);
    chk("arst busy", 32'(busy), 0);
    chk("arst grant_id", 32'(grant_id), 0);
    chk("arst rsp_z", rsp_z, 0);
    chk("arst add_a", add_a, 0);
`ifdef FPADD_ARB_OPCNT_EN
    chk("arst op_count", 32'(op_count), 0);
`endif
    exp_id.delete();
    exp_z.delete();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    z_dly = 2;
    setop(0, FP_ONE, FP_ONE);
    push(0, FP_TWO);
    push(3, 32'h40800000);
    ord_q = '{0, 3};
    req_valid[0] = 1'b1;
    req_valid[3] = 1'b1;
    take_grants(2);
    drain("post rst");
`ifdef FPADD_ARB_OPCNT_EN
    chk("op_count 2", 32'(op_count), 2);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
